// File: rtl/rf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : rf_pkg                                                     |
// | Description : Shared register-file constants and write-back requester    |
// |               indices used by the write-back arbiter and its users.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package rf_pkg;

   localparam int RF_AW       = 5;
   localparam int RF_DW       = 32;
   localparam int RF_NREGS    = 32;
   localparam int RF_ZERO_REG = 0;

   // Requester slot indices on the write-back arbiter
   localparam int WB_ALU  = 0;
   localparam int WB_LOAD = 1;
   localparam int WB_MDU  = 2;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'd0,
      SRC_LOAD = 2'd1,
      SRC_MDU  = 2'd2
   } wb_src_e;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_pick                                                    |
// | Description : Combinational round-robin priority picker. Searches the    |
// |               request vector starting at ptr, ascending with wrap, and   |
// |               returns a one-hot grant for the first set request.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_pick #(
   parameter int NREQ = 3,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt
);

   logic found;
   int   idx;

   // Walk the requesters from ptr with wrap; the first requester found wins
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < NREQ; off++) begin
         idx = (int'(ptr) + off) % NREQ;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_wb_arbiter                                              |
// | Description : Write-back arbiter for the single register-file write      |
// |               port. One holding slot per requester, round-robin grant,   |
// |               writes to $zero dropped, pending-write mask for hazards.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int DW   = RF_DW,
   parameter int AW   = RF_AW
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic                 rf_W_en,
   output logic [AW-1:0]        rf_Waddr,
   output logic [DW-1:0]        rf_Data_In,
   output logic [NREQ-1:0]      grant,
   output logic [(2**AW)-1:0]   pending_mask
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] slot_valid;
   logic [AW-1:0]   slot_addr [NREQ];
   logic [DW-1:0]   slot_data [NREQ];
   logic [PW-1:0]   rr_ptr;

   logic [NREQ-1:0] pick_gnt;
   logic [PW-1:0]   grant_idx;
   logic [NREQ-1:0] accept;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req  (slot_valid),
      .ptr  (rr_ptr),
      .gnt  (pick_gnt)
   );

   // Grant is suppressed while reset is high so no write escapes that cycle
   always_comb begin
      grant = reset ? '0 : pick_gnt;
   end

   // A slot can accept when empty or when it is being drained this cycle
   always_comb begin
      req_ready = reset ? '0 : (~slot_valid | grant);
      accept    = req_valid & req_ready;
   end

   // Drive the write port from the granted slot; zeros when idle
   always_comb begin
      rf_W_en    = 1'b0;
      rf_Waddr   = '0;
      rf_Data_In = '0;
      grant_idx  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            rf_W_en    = 1'b1;
            rf_Waddr   = slot_addr[i];
            rf_Data_In = slot_data[i];
            grant_idx  = PW'(i);
         end
      end
   end

   // Registers with a buffered write; slots never hold register 0
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (slot_valid[i] && !reset) begin
            pending_mask[slot_addr[i]] = 1'b1;
         end
      end
   end

   // Slot storage: accept reloads (or empties on $zero), grant alone clears
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_valid <= '0;
         for (int i = 0; i < NREQ; i++) begin
            slot_addr[i] <= '0;
            slot_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
               slot_valid[i] <= (req_addr[i*AW +: AW] != AW'(RF_ZERO_REG));
               slot_addr[i]  <= req_addr[i*AW +: AW];
               slot_data[i]  <= req_data[i*DW +: DW];
            end else if (grant[i]) begin
               slot_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Round-robin pointer moves past the slot just granted
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (rf_W_en) begin
         rr_ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rf_wb_arbiter                                           |
// | Description : Self-checking bench for rf_wb_arbiter against a slot-level |
// |               behavioural model; directed scenarios plus random traffic. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rf_wb_arbiter;

   localparam int NREQ = 3;
   localparam int DW   = 32;
   localparam int AW   = 5;

   logic              clock = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic              rf_W_en;
   logic [AW-1:0]     rf_Waddr;
   logic [DW-1:0]     rf_Data_In;
   logic [NREQ-1:0]   grant;
   logic [31:0]       pending_mask;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: what each requester has buffered, and who goes next
   bit          m_valid [NREQ];
   logic [4:0]  m_addr  [NREQ];
   logic [31:0] m_data  [NREQ];
   int          m_ptr;
   logic [NREQ-1:0] last_ready;

   rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .rf_W_en      (rf_W_en),
      .rf_Waddr     (rf_Waddr),
      .rf_Data_In   (rf_Data_In),
      .grant        (grant),
      .pending_mask (pending_mask)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREQ; i++) begin
         m_valid[i] = 0;
         m_addr[i]  = '0;
         m_data[i]  = '0;
      end
      m_ptr = 0;
   endtask

   // Requester the model would serve now, or -1 when nothing is buffered
   function automatic int model_pick();
      for (int off = 0; off < NREQ; off++) begin
         if (m_valid[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
      end
      return -1;
   endfunction

   // One clock: drive at negedge, compare outputs, advance the model at posedge
   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                       input logic [NREQ*DW-1:0] d);
      int k;
      logic [NREQ-1:0] e_rdy, e_gnt;
      logic [31:0] e_mask, e_addr, e_data;
      @(negedge clock);
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      #1;
      k = model_pick();
      e_gnt = '0; e_mask = '0; e_addr = '0; e_data = '0;
      if (k >= 0) begin
         e_gnt[k] = 1'b1;
         e_addr   = 32'(m_addr[k]);
         e_data   = m_data[k];
      end
      for (int i = 0; i < NREQ; i++) begin
         e_rdy[i] = !m_valid[i] || (i == k);
         if (m_valid[i]) e_mask[m_addr[i]] = 1'b1;
      end
      check("req_ready",    32'(req_ready),    32'(e_rdy));
      check("grant",        32'(grant),        32'(e_gnt));
      check("rf_W_en",      32'(rf_W_en),      32'(k >= 0));
      check("rf_Waddr",     32'(rf_Waddr),     e_addr);
      check("rf_Data_In",   rf_Data_In,        e_data);
      check("pending_mask", pending_mask,      e_mask);
      last_ready = e_rdy;
      @(posedge clock);
      for (int i = 0; i < NREQ; i++) begin
         if (v[i] && e_rdy[i]) begin
            m_valid[i] = (a[i*AW +: AW] != 5'd0);
            m_addr[i]  = a[i*AW +: AW];
            m_data[i]  = d[i*DW +: DW];
         end else if (i == k) begin
            m_valid[i] = 0;
         end
      end
      if (k >= 0) m_ptr = (k + 1) % NREQ;
   endtask

   function automatic logic [NREQ*AW-1:0] pack_a(input int a0, input int a1, input int a2);
      return {AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   function automatic logic [NREQ*DW-1:0] pack_d(input logic [31:0] d0, input logic [31:0] d1,
                                                 input logic [31:0] d2);
      return {d2, d1, d0};
   endfunction

   logic [NREQ-1:0]    rv;
   logic [NREQ*AW-1:0] ra;
   logic [NREQ*DW-1:0] rd;

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      last_ready = '0;
      model_reset();
      #1;
      check("reset_ready", 32'(req_ready),  32'h0);
      check("reset_wen",   32'(rf_W_en),    32'h0);
      check("reset_grant", 32'(grant),      32'h0);
      check("reset_mask",  pending_mask,    32'h0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Single uncontended write, then drain
      step(3'b001, pack_a(5, 0, 0), pack_d(32'hDEADBEEF, 0, 0));
      step(3'b000, '0, '0);
      step(3'b000, '0, '0);

      // Write to $zero completes the handshake but never issues
      step(3'b010, pack_a(0, 0, 0), pack_d(0, 32'h1234, 0));
      step(3'b000, '0, '0);
      step(3'b000, '0, '0);

      // All requesters contend continuously
      for (int c = 0; c < 9; c++)
         step(3'b111, pack_a(1, 2, 3), pack_d(32'hA0 + c, 32'hB0 + c, 32'hC0 + c));
      for (int c = 0; c < 4; c++) step(3'b000, '0, '0);

      // Back-pressure: req 2 presents a second request while its slot waits
      step(3'b101, pack_a(4, 0, 6), pack_d(32'h44, 0, 32'h66));
      step(3'b100, pack_a(0, 0, 7), pack_d(0, 0, 32'h77));
      step(last_ready[2] ? 3'b000 : 3'b100, pack_a(0, 0, 7), pack_d(0, 0, 32'h77));
      for (int c = 0; c < 4; c++) step(3'b000, '0, '0);

      // Back-to-back stream from req 1
      for (int c = 0; c < 4; c++)
         step(3'b010, pack_a(0, 8 + c, 0), pack_d(0, 32'h1000 + c, 0));
      for (int c = 0; c < 3; c++) step(3'b000, '0, '0);

      // Reset asserted between edges with slots 0 and 1 full
      step(3'b011, pack_a(12, 13, 0), pack_d(32'h12, 32'h13, 0));
      #2;
      reset = 1'b1;
      #1;
      check("midrst_wen",   32'(rf_W_en),    32'h0);
      check("midrst_grant", 32'(grant),      32'h0);
      check("midrst_ready", 32'(req_ready),  32'h0);
      check("midrst_mask",  pending_mask,    32'h0);
      check("midrst_addr",  32'(rf_Waddr),   32'h0);
      model_reset();
      req_valid = '0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) step(3'b000, '0, '0);

      // Random traffic; an unaccepted request is held until it is taken
      rv = '0; ra = '0; rd = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!(rv[i] && !last_ready[i])) begin
               rv[i] = ($urandom_range(0, 9) < 6);
               ra[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
               rd[i*DW +: DW] = $urandom;
            end
         end
         step(rv, ra, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_rf_wb_arbiter
`default_nettype wire
